// File: rtl/sap_ram_param.sv
// SAP RAM block: 2**ADDR_W x DATA_W RAM with its own MAR, synchronous write and asynchronous read.
// It also has a debounced program-mode write button and an optional auto-incrementing program pointer.
module sap_ram_param #(
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_INC        = 0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              prog_mode,
    input  logic [ADDR_W-1:0] dip_addr,
    input  logic [DATA_W-1:0] dip_data,
    input  logic              prog_btn,
    input  logic              addr_load,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              load_mar_n,
    input  logic              ram_in,
    input  logic              ram_out_n,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] addr_out,
    output logic              prog_wr_strobe
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] prog_ptr;
    logic              btn_meta;
    logic              btn_sync;
    logic              btn_state;
    logic              btn_prev;
    logic [CNT_W-1:0]  cnt;
    logic              run_we;
    logic              prog_we;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign addr_out = prog_mode ? mar : prog_ptr;
    assign bus_out  = mem[addr_out];
    assign bus_oe   = ~ram_out_n;

    // A strobe left over from program mode must not write once the panel is switched to run.
    assign run_we  = prog_mode & ram_in;
    assign prog_we = prog_wr_strobe & ~prog_mode;
    assign wr_en   = run_we | prog_we;
    assign wr_addr = prog_mode ? mar : prog_ptr;
    assign wr_data = prog_mode ? bus_in : dip_data;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values;
    // this is what makes a same-edge MAR load and write go to the old address.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mar <= '0;
        end else if (!load_mar_n) begin
            mar <= bus_in[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= prog_btn;
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            btn_state <= 1'b0;
            cnt       <= '0;
        end else if (btn_sync == btn_state) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            btn_state <= btn_sync;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            btn_prev       <= 1'b0;
            prog_wr_strobe <= 1'b0;
        end else begin
            btn_prev       <= btn_state;
            prog_wr_strobe <= btn_state & ~btn_prev & ~prog_mode;
        end
    end

    // Without auto-increment the pointer simply tracks the DIP switches one cycle late.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            prog_ptr <= '0;
        end else if (AUTO_INC == 0 || addr_load) begin
            prog_ptr <= dip_addr;
        end else if (prog_we) begin
            prog_ptr <= prog_ptr + 1'b1;
        end
    end

    // NOTE: the memory array is deliberately not reset; contents stay unknown until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_sap_ram_param.sv
// Bench for sap_ram_param: a constant run-mode vector table, hand-written button sequences, and
// random stimulus compared every cycle against a behavioural model (AUTO_INC=0 and AUTO_INC=1 side by side).
module tb_sap_ram_param;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DC    = 4;
    localparam int DEPTH = 16;

    logic          clk        = 1'b0;
    logic          clr_n      = 1'b0;
    logic          prog_mode  = 1'b1;
    logic          prog_btn   = 1'b0;
    logic          addr_load  = 1'b0;
    logic          load_mar_n = 1'b1;
    logic          ram_in     = 1'b0;
    logic          ram_out_n  = 1'b1;
    logic [AW-1:0] dip_addr   = '0;
    logic [DW-1:0] dip_data   = '0;
    logic [DW-1:0] bus_in     = '0;

    logic [DW-1:0] bus_out0, bus_out1;
    logic          bus_oe0, bus_oe1;
    logic [AW-1:0] addr_out0, addr_out1;
    logic          strobe0, strobe1;

    always #5 clk = ~clk;

    sap_ram_param #(.DATA_W(DW), .ADDR_W(AW), .DEBOUNCE_CYCLES(DC), .AUTO_INC(0)) u_dut0 (
        .clk(clk), .clr_n(clr_n), .prog_mode(prog_mode), .dip_addr(dip_addr), .dip_data(dip_data),
        .prog_btn(prog_btn), .addr_load(addr_load), .bus_in(bus_in), .load_mar_n(load_mar_n),
        .ram_in(ram_in), .ram_out_n(ram_out_n), .bus_out(bus_out0), .bus_oe(bus_oe0),
        .addr_out(addr_out0), .prog_wr_strobe(strobe0)
    );

    sap_ram_param #(.DATA_W(DW), .ADDR_W(AW), .DEBOUNCE_CYCLES(DC), .AUTO_INC(1)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .prog_mode(prog_mode), .dip_addr(dip_addr), .dip_data(dip_data),
        .prog_btn(prog_btn), .addr_load(addr_load), .bus_in(bus_in), .load_mar_n(load_mar_n),
        .ram_in(ram_in), .ram_out_n(ram_out_n), .bus_out(bus_out1), .bus_oe(bus_oe1),
        .addr_out(addr_out1), .prog_wr_strobe(strobe1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Behavioural model: the button is accepted once DC consecutive synchronised samples disagree with it.
    logic [AW-1:0] m_mar, m_ptr0, m_ptr1;
    logic [DW-1:0] m_mem0 [DEPTH];
    logic [DW-1:0] m_mem1 [DEPTH];
    bit            m_val0 [DEPTH];
    bit            m_val1 [DEPTH];
    bit            m_s1, m_s2, m_state, m_rose_prev, m_strobe;
    bit            m_hist [$];

    task automatic model_reset();
        m_mar = '0; m_ptr0 = '0; m_ptr1 = '0;
        m_s1 = 0; m_s2 = 0; m_state = 0; m_rose_prev = 0; m_strobe = 0;
        m_hist.delete();
    endtask

    task automatic model_step();
        bit rose, all_diff, do_wr;
        rose = 0;
        m_hist.push_back(m_s2);
        if (m_hist.size() > DC) void'(m_hist.pop_front());
        if (m_hist.size() == DC) begin
            all_diff = 1;
            foreach (m_hist[i]) if (m_hist[i] == m_state) all_diff = 0;
            if (all_diff) begin
                m_state = !m_state;
                rose    = m_state;
            end
        end
        do_wr = m_strobe && !prog_mode;
        if (prog_mode && ram_in) begin
            m_mem0[m_mar] = bus_in; m_val0[m_mar] = 1;
            m_mem1[m_mar] = bus_in; m_val1[m_mar] = 1;
        end
        if (do_wr) begin
            m_mem0[m_ptr0] = dip_data; m_val0[m_ptr0] = 1;
            m_mem1[m_ptr1] = dip_data; m_val1[m_ptr1] = 1;
        end
        m_ptr0 = dip_addr;
        if (addr_load) m_ptr1 = dip_addr;
        else if (do_wr) m_ptr1 = m_ptr1 + 4'd1;
        if (!load_mar_n) m_mar = bus_in[AW-1:0];
        m_strobe    = m_rose_prev && !prog_mode;
        m_rose_prev = rose;
        m_s2 = m_s1;
        m_s1 = prog_btn;
    endtask

    task automatic model_compare();
        logic [AW-1:0] a0, a1;
        a0 = prog_mode ? m_mar : m_ptr0;
        a1 = prog_mode ? m_mar : m_ptr1;
        check("m_addr0", addr_out0, a0);
        check("m_addr1", addr_out1, a1);
        check("m_strobe0", strobe0, m_strobe);
        check("m_strobe1", strobe1, m_strobe);
        check("m_oe0", bus_oe0, !ram_out_n);
        check("m_oe1", bus_oe1, !ram_out_n);
        if (m_val0[a0]) check("m_out0", bus_out0, m_mem0[a0]);
        if (m_val1[a1]) check("m_out1", bus_out1, m_mem1[a1]);
    endtask

    int strobes = 0;

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_compare();
        strobes += int'(strobe0);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        #1;
        model_reset();
        model_compare();
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
    endtask

    task automatic mar_read(input logic [AW-1:0] a);
        bus_in     = {4'h0, a};
        load_mar_n = 1'b0;
        tick();
        load_mar_n = 1'b1;
    endtask

    typedef struct {
        logic          lm_n;
        logic          ri;
        logic          ro_n;
        logic [DW-1:0] bus;
        logic [AW-1:0] exp_addr;
        logic          chk_out;
        logic [DW-1:0] exp_out;
    } run_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_exp_t;

    run_vec_t rv [9];
    mem_exp_t ai_exp [3];
    mem_exp_t keep_exp [3];
    logic [DW-1:0] ai_data [3];
    int run_left;

    initial begin
        rv[0] = '{1'b0, 1'b0, 1'b1, 8'h05, 4'h5, 1'b0, 8'h00};
        rv[1] = '{1'b1, 1'b1, 1'b1, 8'hA7, 4'h5, 1'b1, 8'hA7};
        rv[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'h5, 1'b1, 8'hA7};
        rv[3] = '{1'b0, 1'b0, 1'b0, 8'h02, 4'h2, 1'b0, 8'h00};
        rv[4] = '{1'b0, 1'b1, 1'b0, 8'h09, 4'h9, 1'b0, 8'h00};
        rv[5] = '{1'b0, 1'b0, 1'b0, 8'h02, 4'h2, 1'b1, 8'h09};
        rv[6] = '{1'b0, 1'b0, 1'b0, 8'h05, 4'h5, 1'b1, 8'hA7};
        rv[7] = '{1'b0, 1'b1, 1'b1, 8'h3C, 4'hC, 1'b0, 8'h00};
        rv[8] = '{1'b0, 1'b0, 1'b0, 8'hF5, 4'h5, 1'b1, 8'h3C};
        ai_exp[0]   = '{4'hE, 8'h11};
        ai_exp[1]   = '{4'hF, 8'h22};
        ai_exp[2]   = '{4'h0, 8'h33};
        keep_exp[0] = '{4'h5, 8'h3C};
        keep_exp[1] = '{4'h2, 8'h09};
        keep_exp[2] = '{4'h3, 8'h77};
        ai_data[0] = 8'h11; ai_data[1] = 8'h22; ai_data[2] = 8'h33;

        do_reset();
        check("reset_addr", addr_out0, 0);
        check("reset_strobe", strobe0, 0);

        // Run-mode writes and reads, including a same-edge MAR load and write.
        prog_mode = 1'b1;
        foreach (rv[i]) begin
            load_mar_n = rv[i].lm_n;
            ram_in     = rv[i].ri;
            ram_out_n  = rv[i].ro_n;
            bus_in     = rv[i].bus;
            tick();
            check("run_addr0", addr_out0, rv[i].exp_addr);
            check("run_addr1", addr_out1, rv[i].exp_addr);
            check("run_oe", bus_oe0, !rv[i].ro_n);
            if (rv[i].chk_out) begin
                check("run_out0", bus_out0, rv[i].exp_out);
                check("run_out1", bus_out1, rv[i].exp_out);
            end
        end

        // Program write: strobe after edge 6, commit at edge 7, only one write while held.
        load_mar_n = 1'b1; ram_in = 1'b0; ram_out_n = 1'b0;
        prog_mode = 1'b0; dip_addr = 4'h3; dip_data = 8'h3C; addr_load = 1'b1; prog_btn = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            check("pw_strobe0", strobe0, e == 6);
            check("pw_strobe1", strobe1, e == 6);
            if (e == 7) begin
                check("pw_mem0", bus_out0, 8'h3C);
                check("pw_mem1", bus_out1, 8'h3C);
            end
        end
        strobes = 0;
        repeat (20) tick();
        prog_btn = 1'b0;
        repeat (8) tick();
        check("pw_hold_release", strobes, 0);

        // Bounce rejection: pulses of 1..3 cycles, then a real press.
        dip_data = 8'h77;
        strobes  = 0;
        for (int len = 1; len <= 3; len++) begin
            prog_btn = 1'b1;
            repeat (len) tick();
            prog_btn = 1'b0;
            repeat (4) tick();
        end
        check("bounce_strobes", strobes, 0);
        check("bounce_mem", bus_out0, 8'h3C);
        prog_btn = 1'b1;
        repeat (8) tick();
        check("bounce_press", strobes, 1);
        check("bounce_write", bus_out0, 8'h77);
        prog_btn = 1'b0;
        repeat (8) tick();

        // Switching to run mode while the strobe is high suppresses the write.
        dip_data = 8'hEE;
        prog_btn = 1'b1;
        repeat (7) tick();
        check("ms_strobe", strobe0, 1);
        prog_mode = 1'b1;
        tick();
        prog_mode = 1'b0;
        #1;
        check("ms_suppress0", bus_out0, 8'h77);
        check("ms_suppress1", bus_out1, 8'h77);
        prog_btn = 1'b0;
        repeat (8) tick();

        // Auto-increment wrap from 0xE.
        addr_load = 1'b1; dip_addr = 4'hE;
        tick();
        addr_load = 1'b0;
        foreach (ai_data[i]) begin
            dip_data = ai_data[i];
            prog_btn = 1'b1;
            repeat (8) tick();
            prog_btn = 1'b0;
            repeat (8) tick();
        end
        check("ai_ptr1", addr_out1, 4'h1);
        check("ai_ptr0", addr_out0, 4'hE);
        prog_mode = 1'b1;
        foreach (ai_exp[i]) begin
            mar_read(ai_exp[i].addr);
            check("ai_mem1", bus_out1, ai_exp[i].data);
            if (i == 0) check("ai_mem0", bus_out0, 8'h33);
        end

        // Reset in the middle of a debounce.
        prog_mode = 1'b0;
        bus_in = 8'h09; load_mar_n = 1'b0; dip_addr = 4'h7; dip_data = 8'h5A;
        tick();
        load_mar_n = 1'b1;
        tick();
        check("pre_rst_ptr0", addr_out0, 4'h7);
        prog_btn = 1'b1;
        repeat (4) tick();
        clr_n = 1'b0;
        #1;
        model_reset();
        check("rst_ptr0", addr_out0, 0);
        check("rst_ptr1", addr_out1, 0);
        check("rst_strobe", strobe0, 0);
        prog_mode = 1'b1;
        #1;
        check("rst_mar", addr_out0, 0);
        prog_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            check("rst_strobe_seq", strobe0, e == 6);
            if (e == 7) check("rst_write", bus_out0, 8'h5A);
        end
        check("rst_ptr1_inc", addr_out1, 4'h1);
        prog_btn = 1'b0;
        repeat (8) tick();
        prog_mode = 1'b1;
        foreach (keep_exp[i]) begin
            mar_read(keep_exp[i].addr);
            check("keep_mem0", bus_out0, keep_exp[i].data);
            check("keep_mem1", bus_out1, keep_exp[i].data);
        end

        // Random stimulus against the model.
        run_left = 0;
        repeat (3000) begin
            if (run_left == 0) begin
                prog_btn = !prog_btn;
                run_left = int'($urandom_range(1, 8));
            end
            run_left--;
            if ($urandom_range(0, 15) == 0) prog_mode = !prog_mode;
            addr_load  = ($urandom_range(0, 7) == 0);
            load_mar_n = ($urandom_range(0, 1) == 1);
            ram_in     = ($urandom_range(0, 1) == 1);
            ram_out_n  = ($urandom_range(0, 1) == 1);
            bus_in     = DW'($urandom);
            dip_addr   = AW'($urandom);
            dip_data   = DW'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
